// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared sizes, opcodes and reorder-buffer entry type
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 3;
  localparam int DATA_W    = 16;
  localparam int REG_W     = 4;
  localparam int FUNC_W    = 4;
  localparam int COUNT_W   = ROB_TAG_W + 1;

  typedef logic [FUNC_W-1:0] func_t;

  localparam func_t OP_ADD   = 4'b0000;
  localparam func_t OP_SUB   = 4'b0001;
  localparam func_t OP_AND   = 4'b0010;
  localparam func_t OP_OR    = 4'b0011;
  localparam func_t OP_LOAD  = 4'b0100;
  localparam func_t OP_STORE = 4'b0101;
  localparam func_t OP_BEQ   = 4'b0110;
  localparam func_t OP_BNEQ  = 4'b0111;

  typedef struct packed {
    logic              busy;
    logic              done;
    func_t             func;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Branch results carry the taken flag in bit 0 of the CDB data.
  function automatic logic is_taken_branch(input rob_entry_t e);
    return ((e.func == OP_BEQ) || (e.func == OP_BNEQ)) && e.data[0];
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping reorder-buffer pointer with increment and clear
module rob_ptr
  import tomasulo_pkg::*;
(
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ROB_TAG_W-1:0] ptr
);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ROB_TAG_W'(1);
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - 8-entry in-order reorder buffer with CDB capture and head commit
// Optional mispredict flush on taken branch commit when ROB_FLUSH_EN is defined.
module rob_commit_unit
  import tomasulo_pkg::*;
(
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [FUNC_W-1:0]    alloc_func,
  input  logic [REG_W-1:0]     alloc_rd,
  output logic [ROB_TAG_W-1:0] alloc_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 commit_valid,
  input  logic                 commit_ready,
  output logic [ROB_TAG_W-1:0] commit_tag,
  output logic [FUNC_W-1:0]    commit_func,
  output logic [REG_W-1:0]     commit_rd,
  output logic [DATA_W-1:0]    commit_data,
  output logic [COUNT_W-1:0]   count,
  output logic                 flush
);

  rob_entry_t           entries [ROB_DEPTH];
  rob_entry_t           head_e;
  logic [ROB_TAG_W-1:0] head;
  logic [ROB_TAG_W-1:0] tail;
  logic                 alloc_fire;
  logic                 commit_fire;
  logic                 cdb_write;

  rob_ptr u_head (.clk1(clk1), .rst(rst), .inc(commit_fire), .clr(flush), .ptr(head));
  rob_ptr u_tail (.clk1(clk1), .rst(rst), .inc(alloc_fire),  .clr(flush), .ptr(tail));

  assign head_e       = entries[head];
  assign commit_valid = head_e.busy && head_e.done;
  assign commit_tag   = head;
  assign commit_func  = head_e.func;
  assign commit_rd    = head_e.rd;
  assign commit_data  = head_e.data;
  assign commit_fire  = commit_valid && commit_ready;

`ifdef ROB_FLUSH_EN
  assign flush = commit_fire && is_taken_branch(head_e);
`else
  assign flush = 1'b0;
`endif

  // No full bypass: a commit in the same cycle does not open a slot.
  assign alloc_ready = (count < COUNT_W'(ROB_DEPTH)) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  // A slot being allocated this cycle was free, so a CDB hit on it is stale.
  assign cdb_write = cdb_valid && entries[cdb_tag].busy && !entries[cdb_tag].done &&
                     !(alloc_fire && (cdb_tag == tail));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (commit_fire) begin
        entries[head].busy <= 1'b0;
      end
      if (alloc_fire) begin
        entries[tail] <= '{busy: 1'b1, done: 1'b0, func: alloc_func, rd: alloc_rd, data: '0};
      end
      if (cdb_write) begin
        entries[cdb_tag].done <= 1'b1;
        entries[cdb_tag].data <= cdb_data;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (alloc_fire && !commit_fire) begin
      count <= count + COUNT_W'(1);
    end else if (commit_fire && !alloc_fire) begin
      count <= count - COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - scoreboard bench for rob_commit_unit
// Build with ROB_FLUSH_EN defined to exercise the flush path.
module tb_rob_commit_unit;
  import tomasulo_pkg::*;

  logic                 clk1;
  logic                 rst;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [FUNC_W-1:0]    alloc_func;
  logic [REG_W-1:0]     alloc_rd;
  logic [ROB_TAG_W-1:0] alloc_tag;
  logic                 cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  logic                 commit_valid;
  logic                 commit_ready;
  logic [ROB_TAG_W-1:0] commit_tag;
  logic [FUNC_W-1:0]    commit_func;
  logic [REG_W-1:0]     commit_rd;
  logic [DATA_W-1:0]    commit_data;
  logic [COUNT_W-1:0]   count;
  logic                 flush;

  rob_commit_unit dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
    .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_func(commit_func), .commit_rd(commit_rd), .commit_data(commit_data),
    .count(count), .flush(flush)
  );

  typedef struct {
    logic [ROB_TAG_W-1:0] tag;
    logic [FUNC_W-1:0]    func;
    logic [REG_W-1:0]     rd;
    logic [DATA_W-1:0]    data;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 e;
  int                   tests = 0;
  int                   fails = 0;
  logic [ROB_TAG_W-1:0] m_tail;
  logic [FUNC_W-1:0]    m_func [ROB_DEPTH];
  logic [REG_W-1:0]     m_rd   [ROB_DEPTH];

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Monitor: every fired commit must match the oldest expected retirement.
  always @(negedge clk1) begin
    if (!rst && commit_valid && commit_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_commit tag=%0d data=%h", commit_tag, commit_data);
      end else begin
        e = sb.pop_front();
        if (commit_tag !== e.tag || commit_func !== e.func ||
            commit_rd !== e.rd || commit_data !== e.data) begin
          fails++;
          $display("FAIL commit got tag=%0d func=%0d rd=%0d data=%h expected tag=%0d func=%0d rd=%0d data=%h",
                   commit_tag, commit_func, commit_rd, commit_data, e.tag, e.func, e.rd, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0;
    cdb_valid = 1'b0;
    commit_ready = 1'b1;
    sb.delete();
    m_tail = '0;
    @(posedge clk1);
    @(posedge clk1);
    #1;
    rst = 1'b0;
  endtask

  task automatic alloc1(input logic [FUNC_W-1:0] f, input logic [REG_W-1:0] r);
    alloc_valid = 1'b1;
    alloc_func = f;
    alloc_rd = r;
    #1;
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    check("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    m_func[m_tail] = f;
    m_rd[m_tail] = r;
    m_tail = m_tail + 3'd1;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic push(input logic [ROB_TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    exp_t x;
    x.tag = t;
    x.func = m_func[t];
    x.rd = m_rd[t];
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic cdb(input logic [ROB_TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1'b1;
    cdb_tag = t;
    cdb_data = d;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_func = '0;
    alloc_rd = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    commit_ready = 1'b1;
    m_tail = '0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_commit_data", 32'(commit_data), 32'd0);
    do_reset();

    // Basic alloc, CDB, commit with minimum latency
    alloc1(OP_ADD, 4'd3);
    #1;
    check("t1_count1", 32'(count), 32'd1);
    check("t1_no_valid", 32'(commit_valid), 32'd0);
    push(3'd0, 16'h1234);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h1234;
    #1;
    check("t1_no_bypass", 32'(commit_valid), 32'd0);
    step();
    cdb_valid = 1'b0;
    #1;
    check("t1_valid", 32'(commit_valid), 32'd1);
    check("t1_rd", 32'(commit_rd), 32'd3);
    check("t1_data", 32'(commit_data), 32'h1234);
    step();
    #1;
    check("t1_count0", 32'(count), 32'd0);

    // Fill to full, rejected 9th alloc, no full bypass
    do_reset();
    commit_ready = 1'b0;
    for (int i = 0; i < 8; i++) alloc1(OP_ADD, 4'(i));
    #1;
    check("t2_count8", 32'(count), 32'd8);
    check("t2_full_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1; alloc_func = OP_SUB; alloc_rd = 4'd15;
    #1;
    check("t2_9th_ready", 32'(alloc_ready), 32'd0);
    step();
    alloc_valid = 1'b0;
    #1;
    check("t2_9th_count", 32'(count), 32'd8);
    push(3'd0, 16'hA000);
    cdb(3'd0, 16'hA000);
    #1;
    check("t2_head_valid", 32'(commit_valid), 32'd1);
    commit_ready = 1'b1;
    alloc_valid = 1'b1; alloc_func = OP_AND; alloc_rd = 4'd7;
    #1;
    check("t2_no_full_bypass", 32'(alloc_ready), 32'd0);
    step();
    #1;
    check("t2_count7", 32'(count), 32'd7);
    check("t2_reopen_tag", 32'(alloc_tag), 32'd0);
    m_func[0] = OP_AND; m_rd[0] = 4'd7; m_tail = 3'd1;
    step();
    alloc_valid = 1'b0;
    #1;
    check("t2_refill_count", 32'(count), 32'd8);
    for (int t = 1; t <= 8; t++) begin
      push(3'(t), 16'hB000 + 16'(t));
      cdb(3'(t), 16'hB000 + 16'(t));
    end
    step();
    step();
    #1;
    check("t2_drained", 32'(count), 32'd0);

    // Out-of-order completion retires in order
    do_reset();
    alloc1(OP_SUB, 4'd5);
    alloc1(OP_AND, 4'd6);
    cdb(3'd1, 16'h0BBB);
    #1;
    check("t3_wait_head", 32'(commit_valid), 32'd0);
    check("t3_count2", 32'(count), 32'd2);
    push(3'd0, 16'h0AAA);
    push(3'd1, 16'h0BBB);
    cdb(3'd0, 16'h0AAA);
    #1;
    check("t3_first_tag", 32'(commit_tag), 32'd0);
    step();
    #1;
    check("t3_second_tag", 32'(commit_tag), 32'd1);
    step();
    #1;
    check("t3_count0", 32'(count), 32'd0);

    // Pointer wrap with overlapping alloc/commit
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'(i);
      #1;
      check("t4_wrap_tag", 32'(alloc_tag), 32'(i % 8));
      m_func[m_tail] = OP_ADD; m_rd[m_tail] = 4'(i); m_tail = m_tail + 3'd1;
      step();
      alloc_valid = 1'b0;
      #1;
      check("t4_steady_count", 32'(count), 32'd1);
      push(3'((i % 8)), 16'h0100 + 16'(i));
      cdb(3'((i % 8)), 16'h0100 + 16'(i));
    end
    step();
    #1;
    check("t4_count0", 32'(count), 32'd0);
    cdb(3'd3, 16'hDEAD);
    #1;
    check("t4_freed_cdb", 32'(commit_valid), 32'd0);
    commit_ready = 1'b0;
    alloc_valid = 1'b1; alloc_func = OP_OR; alloc_rd = 4'd1;
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h5555;
    #1;
    check("t4_same_slot_tag", 32'(alloc_tag), 32'd2);
    m_func[2] = OP_OR; m_rd[2] = 4'd1; m_tail = 3'd3;
    step();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    check("t4_same_slot_ignored", 32'(commit_valid), 32'd0);
    push(3'd2, 16'h1111);
    cdb(3'd2, 16'h1111);
    cdb(3'd2, 16'h2222);
    commit_ready = 1'b1;
    step();
    #1;
    check("t4_done_ignored_count", 32'(count), 32'd0);

    // Taken branch at the head with younger entries behind it
    do_reset();
    commit_ready = 1'b0;
    alloc1(OP_BEQ, 4'd2);
    alloc1(OP_ADD, 4'd1);
    alloc1(OP_ADD, 4'd2);
    alloc1(OP_ADD, 4'd3);
    cdb(3'd1, 16'h0011);
    push(3'd0, 16'h0001);
    cdb(3'd0, 16'h0001);
    commit_ready = 1'b1;
    #1;
    check("t5_branch_valid", 32'(commit_valid), 32'd1);
`ifdef ROB_FLUSH_EN
    check("t5_flush", 32'(flush), 32'd1);
    check("t5_flush_ready", 32'(alloc_ready), 32'd0);
    step();
    #1;
    check("t5_flush_count", 32'(count), 32'd0);
    check("t5_flush_valid", 32'(commit_valid), 32'd0);
    m_tail = '0;
    alloc1(OP_ADD, 4'd9);
`else
    check("t5_no_flush", 32'(flush), 32'd0);
    step();
    #1;
    check("t5_branch_count", 32'(count), 32'd3);
    check("t5_next_head", 32'(commit_tag), 32'd1);
    push(3'd1, 16'h0011);
    step();
    #1;
    check("t5_younger_count", 32'(count), 32'd2);
`endif

    // Asynchronous reset mid-stream discards everything
    do_reset();
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) alloc1(OP_ADD, 4'(i + 1));
    cdb(3'd0, 16'h7777);
    #1;
    check("t6_count5", 32'(count), 32'd5);
    rst = 1'b1;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_valid", 32'(commit_valid), 32'd0);
    check("t6_async_data", 32'(commit_data), 32'd0);
    check("t6_async_tag", 32'(alloc_tag), 32'd0);
    check("t6_async_ready", 32'(alloc_ready), 32'd1);
    commit_ready = 1'b1;
    step();
    rst = 1'b0;
    m_tail = '0;
    alloc1(OP_SUB, 4'd4);
    step();
    #1;
    check("t6_post_count", 32'(count), 32'd1);

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
